// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller.
package hazard_pkg;

  // EX operand 3-way mux select encoding
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // MDU hold FSM state encoding
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE;
  logic [REG_AW-1:0] writeregE, writeregM, writeregW;
  logic              regwriteE, regwriteM, regwriteW;
  logic              memtoregE, memtoregM;
  logic              branchD;
  logic              mdu_startE;

  logic [1:0]        forwardAE, forwardBE;
  logic              forwardAD, forwardBD;
  logic              stallF, stallD, stallE;
  logic              flushE;
  logic              mdu_busy, mdu_done;

  // pipeline side
  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, mdu_startE,
    input  forwardAE, forwardBE, forwardAD, forwardBD,
           stallF, stallD, stallE, flushE, mdu_busy, mdu_done
  );

  // controller side
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, mdu_startE,
    output forwardAE, forwardBE, forwardAD, forwardBD,
           stallF, stallD, stallE, flushE, mdu_busy, mdu_done
  );
endinterface

// File: rtl/hazard_ctrl_mdu_hold_fsm.sv
// Holds the pipeline while the multi-cycle MDU in EX runs.
// Stall covers the start cycle plus MDU_CYCLES busy cycles; the DONE
// cycle releases the hold so EX advances at its end.
module mdu_hold_fsm
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic mdustall,
  output logic busy,
  output logic done
);

  localparam int CW = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_CYCLES - 1);

  mdu_state_e    state;
  logic [CW-1:0] count;

  // state, counter and registered busy/done flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MDU_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            state <= MDU_BUSY;
            count <= CNT_LOAD;
            busy  <= 1'b1;
          end
        end
        MDU_BUSY: begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            state <= MDU_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        MDU_DONE: begin
          // start is still high for the same instruction; ignore it
          state <= MDU_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= MDU_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // stall begins in the start cycle itself, before BUSY is entered
  assign mdustall = ~rst & (((state == MDU_IDLE) & start) | (state == MDU_BUSY));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection and forwarding control for the 5-stage pipeline.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MDU_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [REG_AW-1:0] R0 = '0;

  logic mhit_rsE, mhit_rtE, whit_rsE, whit_rtE;
  logic mhit_rsD, mhit_rtD;
  logic ehit_D, mload_hit_D;
  logic lwstall, brstall, mdustall;
  logic busy, done;

  mdu_hold_fsm #(.MDU_CYCLES(MDU_CYCLES)) u_mdu (
    .clk      (clk),
    .rst      (rst),
    .start    (hz.mdu_startE),
    .mdustall (mdustall),
    .busy     (busy),
    .done     (done)
  );

  // producer matches; register 0 never counts as a producer
  assign mhit_rsE = hz.regwriteM && hz.writeregM != R0 && hz.writeregM == hz.rsE;
  assign mhit_rtE = hz.regwriteM && hz.writeregM != R0 && hz.writeregM == hz.rtE;
  assign whit_rsE = hz.regwriteW && hz.writeregW != R0 && hz.writeregW == hz.rsE;
  assign whit_rtE = hz.regwriteW && hz.writeregW != R0 && hz.writeregW == hz.rtE;
  assign mhit_rsD = hz.regwriteM && hz.writeregM != R0 && hz.writeregM == hz.rsD;
  assign mhit_rtD = hz.regwriteM && hz.writeregM != R0 && hz.writeregM == hz.rtD;

  assign ehit_D      = hz.writeregE != R0 && (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD);
  assign mload_hit_D = hz.writeregM != R0 && (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD);

  assign lwstall = hz.memtoregE && hz.regwriteE && ehit_D;
  assign brstall = hz.branchD && ((hz.regwriteE && ehit_D) || (hz.memtoregM && mload_hit_D));

  // output mux; everything is forced low while reset is held
  always_comb begin
    hz.forwardAE = FWD_RF;
    hz.forwardBE = FWD_RF;
    hz.forwardAD = 1'b0;
    hz.forwardBD = 1'b0;
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.flushE    = 1'b0;
    hz.mdu_busy  = 1'b0;
    hz.mdu_done  = 1'b0;
    if (!rst) begin
      // MEM result is newer than WB, so it wins
      if (mhit_rsE)      hz.forwardAE = FWD_MEM;
      else if (whit_rsE) hz.forwardAE = FWD_WB;
      if (mhit_rtE)      hz.forwardBE = FWD_MEM;
      else if (whit_rtE) hz.forwardBE = FWD_WB;
      hz.forwardAD = mhit_rsD;
      hz.forwardBD = mhit_rtD;
      hz.stallF    = lwstall | brstall | mdustall;
      hz.stallD    = lwstall | brstall | mdustall;
      hz.stallE    = mdustall;
      // EX is held, not bubbled, while the MDU owns it
      hz.flushE    = (lwstall | brstall) & ~mdustall;
      hz.mdu_busy  = busy;
      hz.mdu_done  = done;
    end
  end

endmodule
